// File: rtl/key_sched.sv
// Keystroke scheduler: round-robin arbiter for sources A/B, small key FIFO,
// and a settle window after EQUALS/CLEAR. Macro KEY_SCHED_FILTER_EN discards op codes 9..15.
module key_sched #(
  parameter int DEPTH      = 4,
  parameter int SETTLE_CYC = 3
) (
  input  logic                       clk,
  input  logic                       rst_b,
  input  logic [11:0]                a_key,
  input  logic                       a_valid,
  output logic                       a_ready,
  input  logic [11:0]                b_key,
  input  logic                       b_valid,
  output logic                       b_ready,
  output logic [11:0]                out_key,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic [7:0]                 flush_cnt,
  output logic                       illegal,
  output logic                       dbg_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [3:0] OP_NONE   = 4'd0;
  localparam logic [3:0] OP_EQUALS = 4'd4;
  localparam logic [3:0] OP_CLEAR  = 4'd8;

  typedef enum logic {ST_RUN = 1'b0, ST_SETTLE = 1'b1} state_t;

  logic [11:0]   r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          r_prio;
  logic [7:0]    r_flush;
  logic          r_illegal;
  state_t        r_state;
  logic [3:0]    r_settle;

  logic          w_full;
  logic          w_empty;
  logic          w_a_elig;
  logic          w_b_elig;
  logic          w_grant_a;
  logic          w_grant_b;
  logic          w_gnt;
  logic [11:0]   w_gkey;
  logic [3:0]    w_gop;
  logic          w_is_clear;
  logic          w_push;
  logic          w_out_valid;
  logic          w_pop;
  logic [11:0]   w_head;
  logic [CW-1:0] w_discard;
  logic [8:0]    w_flush_sum;

  // Handshakes: a transfer happens on any cycle where valid and ready are both
  // high; ready is a combinational function of valid and state, valid never waits on ready.
  assign w_full   = (r_count == CW'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_a_elig = a_valid && (!w_full || (a_key[11:8] == OP_CLEAR));
  assign w_b_elig = b_valid && (!w_full || (b_key[11:8] == OP_CLEAR));

  // r_prio = 0 means A holds priority.
  assign w_grant_a = w_a_elig && (!w_b_elig || !r_prio);
  assign w_grant_b = w_b_elig && (!w_a_elig ||  r_prio);
  assign w_gnt     = w_grant_a || w_grant_b;
  assign w_gkey    = w_grant_a ? a_key : b_key;
  assign w_gop     = w_gkey[11:8];
  assign w_is_clear = w_gnt && (w_gop == OP_CLEAR);

`ifdef KEY_SCHED_FILTER_EN
  assign w_push = w_gnt && (w_gop != OP_NONE) && (w_gop < OP_CLEAR);
`else
  assign w_push = w_gnt && (w_gop != OP_NONE) && (w_gop != OP_CLEAR);
`endif

  assign w_out_valid = (r_state == ST_RUN) && !w_empty;
  assign w_pop       = w_out_valid && out_ready;
  assign w_head      = r_mem[r_rd_ptr];

  // A same-cycle pop is a delivery, so it is not counted as flushed.
  assign w_discard   = r_count - {{(CW-1){1'b0}}, w_pop};
  assign w_flush_sum = {1'b0, r_flush} + 9'(w_discard);

  assign a_ready   = w_grant_a;
  assign b_ready   = w_grant_b;
  assign out_valid = w_out_valid;
  assign out_key   = w_out_valid ? w_head : 12'h000;
  assign count     = r_count;
  assign flush_cnt = r_flush;
  assign illegal   = r_illegal;
  assign dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (w_is_clear) begin
      r_mem[0] <= w_gkey;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= w_gkey;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_prio   <= 1'b0;
      r_flush  <= 8'd0;
    end else begin
      if (w_gnt) begin
        r_prio <= w_grant_a;
      end
      if (w_is_clear) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= PW'(1);
        r_count  <= CW'(1);
        r_flush  <= w_flush_sum[8] ? 8'hFF : w_flush_sum[7:0];
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + PW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PW'(1);
        end
        if (w_push && !w_pop) begin
          r_count <= r_count + CW'(1);
        end else if (w_pop && !w_push) begin
          r_count <= r_count - CW'(1);
        end
      end
    end
  end

`ifdef KEY_SCHED_FILTER_EN
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_illegal <= 1'b0;
    end else if (w_gnt && (w_gop > OP_CLEAR)) begin
      r_illegal <= 1'b1;
    end
  end
`else
  assign r_illegal = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state  <= ST_RUN;
      r_settle <= 4'd0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_pop && ((w_head[11:8] == OP_EQUALS) || (w_head[11:8] == OP_CLEAR))) begin
            r_state  <= ST_SETTLE;
            r_settle <= 4'(SETTLE_CYC);
          end
        end
        ST_SETTLE: begin
          if (w_is_clear) begin
            r_settle <= 4'(SETTLE_CYC);
          end else if (r_settle <= 4'd1) begin
            r_state  <= ST_RUN;
            r_settle <= 4'd0;
          end else begin
            r_settle <= r_settle - 4'd1;
          end
        end
        default: begin
          r_state  <= ST_RUN;
          r_settle <= 4'd0;
        end
      endcase
    end
  end

endmodule
